// File: rtl/inst_sram_rsp_if.sv
// Request/response bundle between the fetch unit (master) and the
// instruction SRAM responder (slave).
interface inst_sram_rsp_if;
  logic [3:0]  inst_sram_cen;
  logic        inst_sram_wr;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_cen, inst_sram_wr, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_cen, inst_sram_wr, inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

// File: rtl/inst_sram_rsp.sv
// Instruction SRAM responder: word-addressed RAM behind an address-phase
// handshake, with a response FIFO that returns one in-order data_ok per
// accepted request exactly LATENCY cycles after the handshake.
// Each FIFO entry carries an age that counts down to zero; the head pops
// once its age reaches zero.
// Optional feature: define INST_SRAM_RSP_RAND_STALL_EN to build an LFSR
// that randomly withholds addr_ok and holds the response head.
module inst_sram_rsp #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic            clk,
  input  logic            resetn,
  inst_sram_rsp_if.slave  bus
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [3:0]      AGE_INIT = 4'(LATENCY - 1);

  logic [31:0]           mem_q  [2**ADDR_WIDTH];
  logic [31:0]           data_q [DEPTH];
  logic [3:0]            age_q  [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;

  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  addr_ok_s;
  logic                  push_s;
  logic                  pop_s;
  logic [31:0]           push_data_s;
  logic                  stall_acc_s;
  logic                  hold_s;
  logic                  unused_s;

  assign idx_s    = bus.inst_sram_addr[ADDR_WIDTH+1:2];
  assign unused_s = ^{bus.inst_sram_addr[31:ADDR_WIDTH+2], bus.inst_sram_addr[1:0]};

`ifdef INST_SRAM_RSP_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb_s;

  assign lfsr_fb_s   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign stall_acc_s = lfsr_q[0];
  assign hold_s      = lfsr_q[1];

  // Stall-pattern generator: free-running Fibonacci LFSR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb_s};
    end
  end
`else
  assign stall_acc_s = 1'b0;
  assign hold_s      = 1'b0;
`endif

  // Handshake and pop decisions; addr_ok depends only on registered occupancy.
  always_comb begin
    addr_ok_s   = resetn & (count_q < DEPTH_C) & ~stall_acc_s;
    push_s      = addr_ok_s & (bus.inst_sram_cen != 4'h0);
    pop_s       = (count_q != {CW{1'b0}}) & (age_q[rd_ptr_q] == 4'h0) & ~hold_s;
    push_data_s = bus.inst_sram_wr ? 32'h0 : mem_q[idx_s];
  end

  assign bus.inst_sram_addr_ok = addr_ok_s;
  assign bus.inst_sram_data_ok = pop_s;
  assign bus.inst_sram_rdata   = pop_s ? data_q[rd_ptr_q] : 32'h0;

  // Byte-enabled RAM write at the handshake edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (push_s && bus.inst_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.inst_sram_cen[b]) begin
          mem_q[idx_s][8*b +: 8] <= bus.inst_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response FIFO: age countdown, push/pop pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 32'h0;
        age_q[i]  <= 4'h0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= (age_q[i] != 4'h0) ? (age_q[i] - 4'h1) : 4'h0;
      end
      if (push_s) begin
        data_q[wr_ptr_q] <= push_data_s;
        age_q[wr_ptr_q]  <= AGE_INIT;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_rsp.sv
// Self-checking bench for inst_sram_rsp. Two instances are exercised:
// dut0 with the default LATENCY=2/DEPTH=4 and dut1 with LATENCY=8/DEPTH=4.
// A transaction-log scoreboard (each accepted request gets a due cycle and
// an expected word) and a word-array memory model give every expected value.
module tb_inst_sram_rsp;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  inst_sram_rsp_if bus0();
  inst_sram_rsp_if bus1();

  inst_sram_rsp #(.ADDR_WIDTH(12), .LATENCY(2), .DEPTH(4)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0.slave));
  inst_sram_rsp #(.ADDR_WIDTH(12), .LATENCY(8), .DEPTH(4)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1.slave));

  int          lat_k [2];
  int          dep_k [2];
  logic [31:0] mref    [2][4096];
  bit          mknown  [2][4096];
  logic [31:0] ex_data [2][8192];
  bit          ex_known[2][8192];
  int          ex_due  [2][8192];
  int          n_push [2];
  int          n_pop  [2];
  int          hs_cnt [2];
  int          dok_cnt[2];
  int          aok_low[2];
  logic        obs_aok[2];
  logic        obs_dok[2];
  logic [31:0] obs_rd [2];
  int          cyc;
  int          n_assert;
  int          n_fail;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  task automatic set_req(int k, logic [3:0] cen, logic wr, logic [31:0] addr, logic [31:0] wd);
    if (k == 0) begin
      bus0.inst_sram_cen = cen; bus0.inst_sram_wr = wr;
      bus0.inst_sram_addr = addr; bus0.inst_sram_wdata = wd;
    end else begin
      bus1.inst_sram_cen = cen; bus1.inst_sram_wr = wr;
      bus1.inst_sram_addr = addr; bus1.inst_sram_wdata = wd;
    end
  endtask

  // Compare one DUT's outputs for the current cycle and advance its model.
  task automatic model_step(int k, logic aok, logic dok, logic [31:0] rd,
                            logic [3:0] cen, logic wr, logic [31:0] addr, logic [31:0] wd);
    int   outst;
    int   idx;
    logic e_aok;
    logic e_dok;
    logic hand;
    logic allowed;
    outst = n_push[k] - n_pop[k];
    idx   = int'(addr[13:2]);
    obs_aok[k] = aok; obs_dok[k] = dok; obs_rd[k] = rd;
    if (!resetn) begin
      chk("reset_addr_ok", {31'b0, aok}, 32'h0);
      chk("reset_data_ok", {31'b0, dok}, 32'h0);
      chk("reset_rdata", rd, 32'h0);
      n_pop[k] = n_push[k];
      return;
    end
    if (!aok) aok_low[k]++;
`ifndef INST_SRAM_RSP_RAND_STALL_EN
    e_aok = (outst < dep_k[k]);
    e_dok = (outst > 0) && (ex_due[k][n_pop[k]] == cyc);
    chk("addr_ok", {31'b0, aok}, {31'b0, e_aok});
    chk("data_ok", {31'b0, dok}, {31'b0, e_dok});
`else
    e_aok = aok;
    if (outst >= dep_k[k]) chk("addr_ok_when_full", {31'b0, aok}, 32'h0);
    allowed = (outst > 0) && (ex_due[k][n_pop[k]] <= cyc);
    if (dok) chk("data_ok_allowed", {31'b0, allowed}, 32'h1);
    e_dok = dok && allowed;
`endif
    if (e_dok && ex_known[k][n_pop[k]]) chk("rdata", rd, ex_data[k][n_pop[k]]);
    if (!e_dok) chk("rdata_idle", rd, 32'h0);
    if (e_dok) begin
      n_pop[k]++;
      dok_cnt[k]++;
    end
    hand = e_aok && (cen != 4'h0);
    if (hand) begin
      ex_due[k][n_push[k]] = cyc + lat_k[k];
      if (wr) begin
        ex_data[k][n_push[k]]  = 32'h0;
        ex_known[k][n_push[k]] = 1'b1;
        for (int b = 0; b < 4; b++)
          if (cen[b]) mref[k][idx][8*b +: 8] = wd[8*b +: 8];
        if (cen == 4'hF) mknown[k][idx] = 1'b1;
      end else begin
        ex_data[k][n_push[k]]  = mref[k][idx];
        ex_known[k][n_push[k]] = mknown[k][idx];
      end
      n_push[k]++;
      hs_cnt[k]++;
    end
  endtask

  // One clock cycle: check at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    model_step(0, bus0.inst_sram_addr_ok, bus0.inst_sram_data_ok, bus0.inst_sram_rdata,
               bus0.inst_sram_cen, bus0.inst_sram_wr, bus0.inst_sram_addr, bus0.inst_sram_wdata);
    model_step(1, bus1.inst_sram_addr_ok, bus1.inst_sram_data_ok, bus1.inst_sram_rdata,
               bus1.inst_sram_cen, bus1.inst_sram_wr, bus1.inst_sram_addr, bus1.inst_sram_wdata);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic write_wait(int k, logic [31:0] addr, logic [31:0] wd);
    int h0;
    int n;
    h0 = hs_cnt[k];
    n  = 0;
    set_req(k, 4'hF, 1'b1, addr, wd);
    while (hs_cnt[k] == h0 && n < 50) begin
      tick();
      n++;
    end
    set_req(k, 4'h0, 1'b0, 32'h0, 32'h0);
    chk("preload_accept", hs_cnt[k] - h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    lat_k[0] = 2; lat_k[1] = 8;
    dep_k[0] = 4; dep_k[1] = 4;
    for (int k = 0; k < 2; k++) begin
      n_push[k] = 0; n_pop[k] = 0; hs_cnt[k] = 0; dok_cnt[k] = 0; aok_low[k] = 0;
      for (int i = 0; i < 4096; i++) mknown[k][i] = 1'b0;
    end
    cyc = 0; n_assert = 0; n_fail = 0;
    set_req(0, 4'h0, 1'b0, 32'h0, 32'h0);
    set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);

    // Reset state
    resetn = 1'b1;
    #2 resetn = 1'b0;
    @(posedge clk); #1;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("first_cycle_addr_ok0", {31'b0, obs_aok[0]}, 32'h1);
    chk("first_cycle_addr_ok1", {31'b0, obs_aok[1]}, 32'h1);

`ifndef INST_SRAM_RSP_RAND_STALL_EN
    // Write 0xDEADBEEF to 0x40, read it back next cycle
    set_req(0, 4'hF, 1'b1, 32'h40, 32'hDEADBEEF); tick();
    set_req(0, 4'hF, 1'b0, 32'h40, 32'h0);        tick();
    set_req(0, 4'h0, 1'b0, 32'h0, 32'h0);         tick();
    chk("wr_rsp_data_ok", {31'b0, obs_dok[0]}, 32'h1);
    chk("wr_rsp_rdata", obs_rd[0], 32'h0);
    tick();
    chk("rd_rsp_data_ok", {31'b0, obs_dok[0]}, 32'h1);
    chk("rd_rsp_rdata", obs_rd[0], 32'hDEADBEEF);

    // Byte-enabled write merge
    set_req(0, 4'hF, 1'b1, 32'h10, 32'h11223344); tick();
    set_req(0, 4'h5, 1'b1, 32'h10, 32'hAABBCCDD); tick();
    set_req(0, 4'hF, 1'b0, 32'h10, 32'h0);        tick();
    set_req(0, 4'h0, 1'b0, 32'h0, 32'h0);         tick();
    tick();
    chk("byte_merge_data_ok", {31'b0, obs_dok[0]}, 32'h1);
    chk("byte_merge_rdata", obs_rd[0], 32'h11BB33DD);
`endif

    // Preload words 0..31 with their index in both instances
    for (int i = 0; i < 32; i++) write_wait(0, 32'(i * 4), 32'(i));
    for (int i = 0; i < 32; i++) write_wait(1, 32'(i * 4), 32'(i));
    repeat (12) tick();

    // Streaming: 8 back-to-back reads on dut0
    dok_cnt[0] = 0; aok_low[0] = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 4'hF, 1'b0, 32'(i * 4), 32'h0);
      tick();
    end
    set_req(0, 4'h0, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();
    chk("stream_responses", dok_cnt[0], 32'd8);
`ifndef INST_SRAM_RSP_RAND_STALL_EN
    chk("stream_addr_ok_low", aok_low[0], 32'd0);

    // Full FIFO on dut1 (LATENCY 8, DEPTH 4)
    hs_cnt[1] = 0;
    for (int i = 0; i < 5; i++) begin
      set_req(1, 4'hF, 1'b0, 32'(i * 4), 32'h0);
      tick();
    end
    chk("full_handshakes", hs_cnt[1], 32'd4);
    chk("full_addr_ok", {31'b0, obs_aok[1]}, 32'h0);
`endif
    for (int i = 0; i < 20; i++) begin
      set_req(1, 4'hF, 1'b0, 32'((i % 32) * 4), 32'h0);
      tick();
    end
    set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);
    repeat (40) tick();
    chk("full_drained", n_push[1] - n_pop[1], 32'd0);

    // Reset with three reads outstanding on dut1
    for (int i = 0; i < 3; i++) begin
      set_req(1, 4'hF, 1'b0, 32'(i * 4 + 12), 32'h0);
      tick();
    end
    set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);
    chk("outstanding_before_reset", n_push[1] - n_pop[1], 32'd3);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    dok_cnt[1] = 0;
    tick();
    chk("post_reset_addr_ok", {31'b0, obs_aok[1]}, 32'h1);
    set_req(1, 4'hF, 1'b0, 32'h14, 32'h0);
    tick();
    set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);
    repeat (40) tick();
    chk("post_reset_responses", dok_cnt[1], 32'd1);

    // Random reads/writes on both instances
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 2; k++) begin
        r = int'($urandom_range(0, 9));
        a = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 31)) << 2);
        if (r < 2)      set_req(k, 4'h0, 1'b0, a, $urandom);
        else if (r < 5) set_req(k, 4'($urandom_range(1, 15)), 1'b1, a, $urandom);
        else            set_req(k, 4'hF, 1'b0, a, $urandom);
      end
      tick();
    end
    set_req(0, 4'h0, 1'b0, 32'h0, 32'h0);
    set_req(1, 4'h0, 1'b0, 32'h0, 32'h0);
    repeat (80) tick();
    chk("random_drained0", n_push[0] - n_pop[0], 32'd0);
    chk("random_drained1", n_push[1] - n_pop[1], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sram_rsp.md
# inst_sram_rsp

Responder end of the `inst_sram_*` request/response interface that the fetch unit drives. It sits in the SoC wrapper in front of a word-addressed on-chip instruction RAM. It accepts address-phase requests with `inst_sram_addr_ok` and returns exactly one in-order `inst_sram_data_ok` pulse per accepted request after a fixed latency. It supports multiple outstanding requests, so a prefetching master can pipeline its fetches.

## Interface
- `ADDR_WIDTH`, 12: word-index bits; memory holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: cycles from handshake to `data_ok`; legal values 1..15.
- `DEPTH`, 4: response FIFO entries, power of 2, at least 2. `DEPTH >= LATENCY+1` is required for full throughput.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous assert, active-low.
- `inst_sram_cen` in 4: byte enables. Request is valid when nonzero. Reads use 4'b1111.
- `inst_sram_wr` in 1: 1 = write, 0 = read.
- `inst_sram_addr` in 32: byte address. Bits [ADDR_WIDTH+1:2] index the memory. Other bits are ignored, so addresses alias.
- `inst_sram_wdata` in 32: write data.
- `inst_sram_addr_ok` out 1: request accepted this cycle when valid.
- `inst_sram_data_ok` out 1: one-cycle response pulse.
- `inst_sram_rdata` out 32: read data, valid only while `data_ok` is high.

## Operation
- Handshake: in any cycle with `cen != 0` and `addr_ok = 1`. The master has no data-phase backpressure, so the block must never drop a response.
- Read: memory is read at the handshake edge. Data plus an age counter set to `LATENCY-1` are pushed into the response FIFO.
- Write: bytes with `cen[i]` set are written at the handshake edge. An entry with data 32'h0 is still pushed, so a write also returns one `data_ok`.
- Ordering: a read handshaken in a later cycle than a write to the same word returns the new data.
- Ages: each valid entry's age decrements every cycle and saturates at 0.
- Pop: the head pops when it is valid and its age is 0 (and it is not held; see Configuration). `data_ok = 1` and `rdata = head.data` in that cycle. Otherwise `rdata = 32'h0`.
- `addr_ok = (count < DEPTH)` while `resetn` is high.
  - `count` is the registered occupancy. A pop in the same cycle does not raise `addr_ok`, so there is no combinational path from pop to `addr_ok`.
- Full: no handshake is possible, and stalled request inputs are ignored. Empty: `data_ok = 0`.
- Simultaneous push and pop: `count` is unchanged, and both pointers wrap modulo `DEPTH`.
- Memory is not reset and its contents are undefined until written.

## Timing
- Reset (`resetn` low, asynchronous): FIFO is emptied, `count = 0`, `addr_ok = 0`, `data_ok = 0`, `rdata = 0`.
- Reset mid-operation: outstanding responses are discarded and never returned. Writes already committed remain in memory.
- First cycle after `resetn` rises: `addr_ok = 1`.
- Request handshaken in cycle N: `data_ok` is high in cycle N+LATENCY when no hold is in effect.
- Throughput: one request and one response per cycle.

## Configuration
- Macro `INST_SRAM_RSP_RAND_STALL_EN` turns on random stall injection for verification.
- Defined:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 is seeded with 16'hACE1 on reset and advances every cycle.
  - `lfsr[0] = 1` forces `addr_ok = 0` that cycle.
  - `lfsr[1] = 1` holds the head: no pop and `data_ok = 0`. Ages keep decrementing and saturating, and later entries queue behind the head.
  - Order and one-response-per-request still hold.
- Undefined: no LFSR is built. `addr_ok` depends only on occupancy, and `data_ok` occurs exactly at N+LATENCY.

## Test plan
- Write then read, defaults: write 32'hDEADBEEF with `cen = 4'hF` to `addr` 0x40 in cycle 0, then read 0x40 in cycle 1 -> `data_ok` in cycles 2 and 3, with rdata 32'h0 in cycle 2 and 32'hDEADBEEF in cycle 3.
- Byte write: preload 0x10 with 32'h11223344, write 32'hAABBCCDD with `cen = 4'b0101`, then read -> 32'h11BB33DD.
- Streaming, LATENCY=2, DEPTH=4: 8 back-to-back reads of words 0..7 preloaded with their indices -> `addr_ok` never low, `data_ok` high 8 consecutive cycles starting 2 cycles after the first handshake, rdata 0..7 in order.
- Full FIFO: with LATENCY=8, DEPTH=4, issue continuous reads -> `addr_ok` low after 4 handshakes, first `data_ok` 8 cycles after the first handshake, no lost or duplicated responses.
- Reset mid-flight: assert `resetn` low for 1 cycle with 3 reads outstanding -> `data_ok` stays 0 and `addr_ok` returns 1 the cycle after release. A following read returns correct data at N+LATENCY.
- With `INST_SRAM_RSP_RAND_STALL_EN`: 1000 random reads and writes against a scoreboard model -> every accepted request gets exactly one in-order `data_ok` with matching data.
